// File: rtl/ysyx_24080014_rd_arbiter.sv
// Two-master to one-slave AXI4-Lite read arbiter (IFU = m0, LSU = m1).
// One outstanding transaction; the address is registered toward the slave,
// and the R channel is a combinational pass-through to the granted master.
// Optional macro YSYX_24080014_ARB_RR_EN selects round-robin priority;
// without it the LSU always wins a contested cycle.
module ysyx_24080014_rd_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          m0_arvalid,
    output logic          m0_arready,
    input  logic [AW-1:0] m0_araddr,
    output logic          m0_rvalid,
    input  logic          m0_rready,
    output logic [DW-1:0] m0_rdata,
    output logic [1:0]    m0_rresp,
    input  logic          m1_arvalid,
    output logic          m1_arready,
    input  logic [AW-1:0] m1_araddr,
    output logic          m1_rvalid,
    input  logic          m1_rready,
    output logic [DW-1:0] m1_rdata,
    output logic [1:0]    m1_rresp,
    output logic          s_arvalid,
    input  logic          s_arready,
    output logic [AW-1:0] s_araddr,
    input  logic          s_rvalid,
    output logic          s_rready,
    input  logic [DW-1:0] s_rdata,
    input  logic [1:0]    s_rresp,
    output logic          busy,
    output logic          grant
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t state, state_nxt;
    logic   win;

`ifdef YSYX_24080014_ARB_RR_EN
    logic last;

    // Round-robin: on contention the master not served last time wins.
    always_comb begin
        win = (m0_arvalid && m1_arvalid) ? ~last : m1_arvalid;
    end

    // Round-robin history, updated on every accepted address.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset)
            last <= 1'b0;
        else if (state == IDLE && (m0_arvalid || m1_arvalid))
            last <= win;
    end
`else
    // Fixed priority: the LSU wins whenever it requests.
    always_comb begin
        win = m1_arvalid;
    end
`endif

    // State, captured address and grant index.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state    <= IDLE;
            s_araddr <= '0;
            grant    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (m0_arvalid || m1_arvalid)) begin
                s_araddr <= win ? m1_araddr : m0_araddr;
                grant    <= win;
            end
        end
    end

    // Next state and all handshake/routing outputs.
    always_comb begin
        state_nxt  = state;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        s_rready   = 1'b0;
        s_arvalid  = 1'b0;
        // Non-granted master's data is don't-care, so both see the slave bus.
        m0_rdata   = s_rdata;
        m1_rdata   = s_rdata;
        m0_rresp   = s_rresp;
        m1_rresp   = s_rresp;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                m0_arready = m0_arvalid && !win;
                m1_arready = m1_arvalid && win;
                if (m0_arvalid || m1_arvalid)
                    state_nxt = ADDR;
            end
            ADDR: begin
                s_arvalid = 1'b1;
                if (s_arready)
                    state_nxt = DATA;
            end
            DATA: begin
                m0_rvalid = s_rvalid && !grant;
                m1_rvalid = s_rvalid && grant;
                s_rready  = grant ? m1_rready : m0_rready;
                if (s_rvalid && s_rready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24080014_rd_arbiter.sv
// Self-checking bench for ysyx_24080014_rd_arbiter: directed scenarios plus
// randomized transactions checked against a transaction-level model.
module tb_ysyx_24080014_rd_arbiter;

    logic        aclk = 1'b0;
    logic        areset;
    logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [31:0] m0_araddr, m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [31:0] m1_araddr, m1_rdata;
    logic [1:0]  m1_rresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        busy, grant;

    int tests = 0;
    int fails = 0;
    bit last_exp = 1'b0;

`ifdef YSYX_24080014_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    always #5 aclk = ~aclk;

    ysyx_24080014_rd_arbiter #(.AW(32), .DW(32)) dut (
        .aclk(aclk), .areset(areset),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .busy(busy), .grant(grant)
    );

    // One full read transaction starting in IDLE, just after a falling edge.
    // The model picks the winner from the arbitration rules; hold keeps the
    // loser's request up so it is granted right after this one completes.
    task automatic do_txn(input bit r0, input bit r1, input logic [31:0] a0,
                          input logic [31:0] a1, input bit hold, input int ar_wait,
                          input int r_wait, input int stall, input logic [31:0] data,
                          input logic [1:0] resp);
        bit w;
        logic [31:0] wa;
        m0_arvalid = r0; m0_araddr = a0;
        m1_arvalid = r1; m1_araddr = a1;
        if (r0 && r1) w = RR_EN ? !last_exp : 1'b1;
        else          w = r1;
        wa = w ? a1 : a0;
        #1;
        tests++;
        if (m0_arready !== (r0 && !w) || m1_arready !== (r1 && w)) begin
            fails++;
            $display("FAIL arready: got m0=%b m1=%b want m0=%b m1=%b", m0_arready, m1_arready, r0 && !w, r1 && w);
        end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL idle_busy: got %b want 0", busy); end
        @(negedge aclk);
        if (w) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
        if (!hold) begin m0_arvalid = 1'b0; m1_arvalid = 1'b0; end
        last_exp = w;
        #1;
        tests++;
        if (s_arvalid !== 1'b1 || s_araddr !== wa || grant !== w || busy !== 1'b1) begin
            fails++;
            $display("FAIL addr_phase: got arvalid=%b addr=%h grant=%b busy=%b want 1 %h %b 1", s_arvalid, s_araddr, grant, busy, wa, w);
        end
        tests++;
        if (m0_arready !== 1'b0 || m1_arready !== 1'b0) begin
            fails++; $display("FAIL busy_arready: got m0=%b m1=%b want 0 0", m0_arready, m1_arready);
        end
        repeat (ar_wait) @(negedge aclk);
        s_arready = 1'b1;
        #1;
        tests++;
        if (s_arvalid !== 1'b1 || s_araddr !== wa) begin
            fails++; $display("FAIL addr_hold: got arvalid=%b addr=%h want 1 %h", s_arvalid, s_araddr, wa);
        end
        @(negedge aclk);
        s_arready = 1'b0;
        #1;
        tests++;
        if (s_arvalid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL data_entry: got arvalid=%b busy=%b want 0 1", s_arvalid, busy);
        end
        repeat (r_wait) @(negedge aclk);
        s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
        for (int i = 0; i < stall; i++) begin
            #1;
            tests++;
            if (s_rready !== 1'b0 || (w ? m1_rvalid : m0_rvalid) !== 1'b1 ||
                (w ? m0_rvalid : m1_rvalid) !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL stall: got s_rready=%b rv0=%b rv1=%b busy=%b (grant %b)", s_rready, m0_rvalid, m1_rvalid, busy, w);
            end
            @(negedge aclk);
        end
        if (w) m1_rready = 1'b1; else m0_rready = 1'b1;
        #1;
        tests++;
        if (s_rready !== 1'b1 || (w ? m1_rvalid : m0_rvalid) !== 1'b1 ||
            (w ? m0_rvalid : m1_rvalid) !== 1'b0 ||
            (w ? m1_rdata : m0_rdata) !== data || (w ? m1_rresp : m0_rresp) !== resp) begin
            fails++;
            $display("FAIL rdata: got s_rready=%b rv0=%b rv1=%b d0=%h d1=%h r0=%b r1=%b want data=%h resp=%b grant=%b",
                     s_rready, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata, m0_rresp, m1_rresp, data, resp, w);
        end
        @(negedge aclk);
        s_rvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
        #1;
        tests++;
        if (busy !== 1'b0 || s_rready !== 1'b0 || m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
            fails++; $display("FAIL back_idle: got busy=%b s_rready=%b rv0=%b rv1=%b want 0", busy, s_rready, m0_rvalid, m1_rvalid);
        end
        if (hold && r0 && r1) begin
            tests++;
            if ((w ? m0_arready : m1_arready) !== 1'b1) begin
                fails++; $display("FAIL back_to_back: loser arready got 0 want 1");
            end
        end
    endtask

    task automatic test_reset;
        areset = 1'b1;
        m0_arvalid = 0; m0_araddr = 0; m0_rready = 0;
        m1_arvalid = 0; m1_araddr = 0; m1_rready = 0;
        s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0;
        #3;
        tests++;
        if (s_arvalid !== 0 || s_araddr !== 32'h0 || grant !== 0 || busy !== 0 ||
            m0_arready !== 0 || m1_arready !== 0 || m0_rvalid !== 0 || m1_rvalid !== 0 || s_rready !== 0) begin
            fails++;
            $display("FAIL reset: got arvalid=%b addr=%h grant=%b busy=%b rready=%b want all 0", s_arvalid, s_araddr, grant, busy, s_rready);
        end
        @(negedge aclk); @(negedge aclk);
        areset = 1'b0;
        last_exp = 1'b0;
    endtask

    task automatic test_single_ifu;
        do_txn(1, 0, 32'h8000_0000, 32'h0, 0, 2, 1, 0, 32'h0000_0413, 2'b00);
    endtask

    task automatic test_simultaneous;
        do_txn(1, 1, 32'h8000_0004, 32'h8000_1000, 1, 0, 0, 0, 32'h1111_0001, 2'b00);
        do_txn(m0_arvalid, m1_arvalid, 32'h8000_0004, 32'h8000_1000, 0, 0, 0, 0, 32'h1111_0002, 2'b00);
    endtask

    task automatic test_contested_rounds;
        for (int i = 0; i < 4; i++)
            do_txn(1, 1, 32'h8000_0004, 32'h8000_1000, 0, 0, 0, 0, 32'h2222_0000 + i, 2'b00);
    endtask

    task automatic test_backpressure;
        do_txn(1, 0, 32'h8000_0010, 32'h0, 0, 0, 0, 5, 32'hDEAD_BEEF, 2'b00);
    endtask

    task automatic test_error_resp;
        do_txn(0, 1, 32'h0, 32'h0000_0000, 0, 1, 0, 0, 32'h0BAD_0BAD, 2'b10);
    endtask

    task automatic test_reset_mid_data;
        m1_arvalid = 1'b1; m1_araddr = 32'h8000_2000;
        @(negedge aclk);
        m1_arvalid = 1'b0; s_arready = 1'b1;
        @(negedge aclk);
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA;
        #1;
        tests++;
        if (m1_rvalid !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL pre_reset_data: got rv1=%b busy=%b want 1 1", m1_rvalid, busy);
        end
        #2 areset = 1'b1;
        #1;
        tests++;
        if (m0_rvalid !== 0 || m1_rvalid !== 0 || s_rready !== 0 || s_arvalid !== 0 || busy !== 0 || grant !== 0) begin
            fails++;
            $display("FAIL mid_reset: got rv0=%b rv1=%b s_rready=%b arvalid=%b busy=%b grant=%b want 0", m0_rvalid, m1_rvalid, s_rready, s_arvalid, busy, grant);
        end
        @(negedge aclk);
        areset = 1'b0; s_rvalid = 1'b0;
        last_exp = 1'b0;
        #1;
        do_txn(1, 0, 32'h8000_0020, 32'h0, 0, 1, 1, 1, 32'hCAFE_F00D, 2'b00);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            bit r0, r1;
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            do_txn(r0, r1, $urandom, $urandom, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom, 2'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset;
        test_single_ifu;
        test_simultaneous;
        test_contested_rounds;
        test_backpressure;
        test_error_resp;
        test_reset_mid_data;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
